// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: 32-iteration shift-add multiply and restoring divide,
// plus direct HI/LO moves. A result lands in HI/LO at the FIX edge, 33 cycles after acceptance.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_a;          // multiplicand or divisor magnitude
    logic [63:0] r_p;          // mul: {partial, multiplier}; div: {remainder, quotient}
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_idle;
    logic        w_accept_md;
    logic        w_accept_mt;
    logic        w_signed;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_sh;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [63:0] w_iter;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept_md = w_idle && start && (op[2] == 1'b0);
    assign w_accept_mt = w_idle && start && (op[2:1] == 2'b10);

    // Signed ops (MULT, DIV) iterate on magnitudes; the signs are reapplied in FIX.
    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & rs_val[31];
    assign w_rt_neg = w_signed & rt_val[31];
    assign w_rs_mag = w_rs_neg ? (32'd0 - rs_val) : rs_val;
    assign w_rt_mag = w_rt_neg ? (32'd0 - rt_val) : rt_val;

    assign w_mul_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_a} : 33'd0);
    assign w_div_sh   = {r_p[63:32], r_p[31]};
    assign w_div_diff = w_div_sh - {1'b0, r_a};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_a});

    always_comb begin
        w_iter = {w_mul_sum, r_p[31:1]};
        if (r_is_div) begin
            if (w_div_ge) w_iter = {w_div_diff[31:0], r_p[30:0], 1'b1};
            else          w_iter = {w_div_sh[31:0],   r_p[30:0], 1'b0};
        end
    end

    // A zero divisor leaves |rs| in the remainder, so only the quotient needs forcing.
    assign w_prod_fix = r_neg_q ? (64'd0 - r_p) : r_p;
    assign w_quo_fix  = r_div0 ? 32'hFFFF_FFFF
                               : (r_neg_q ? (32'd0 - r_p[31:0]) : r_p[31:0]);
    assign w_rem_fix  = r_neg_r ? (32'd0 - r_p[63:32]) : r_p[63:32];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept_md) w_next = S_RUN;
            S_RUN:   if (r_cnt == 6'd1) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_a      <= 32'd0;
            r_p      <= 64'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept_md) begin
                        r_cnt    <= 6'd32;
                        r_is_div <= op[1];
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_div0   <= op[1] && (rt_val == 32'd0);
                        r_a      <= op[1] ? w_rt_mag : w_rs_mag;
                        r_p      <= {32'd0, (op[1] ? w_rs_mag : w_rt_mag)};
                    end else if (w_accept_mt) begin
                        if (op[0]) r_lo <= rs_val;
                        else       r_hi <= rs_val;
                        r_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_p   <= w_iter;
                    r_cnt <= r_cnt - 6'd1;
                end
                S_FIX: begin
                    r_hi   <= r_is_div ? w_rem_fix : w_prod_fix[63:32];
                    r_lo   <= r_is_div ? w_quo_fix : w_prod_fix[31:0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HI          = r_hi;
    assign LO          = r_lo;
    assign done        = r_done;
    assign busy        = ~w_idle;
    assign o_dbg_state = r_state;

endmodule
